// File: rtl/complex_counter_monitor.sv
// rtl/complex_counter_monitor.sv - detects binary/Gray mode of a 3-bit counter stream and flags sequence breaks
module complex_counter_monitor #(
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       count,
    input  logic             valid,
    output logic             locked,
    output logic             mode_det,
    output logic [2:0]       index,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic             mode_q, mode_d;
    logic [2:0]       index_q, index_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    function automatic logic [2:0] g2b(input logic [2:0] x);
        logic [2:0] b;
        b[2] = x[2];
        b[1] = x[2] ^ x[1];
        b[0] = x[2] ^ x[1] ^ x[0];
        return b;
    endfunction

    logic [2:0] bin_next;
    logic [2:0] gray_next;
    logic [2:0] count_dec;
    logic       bin_ok;
    logic       gray_ok;
    logic       mode_ok;

    always_comb begin
        bin_next  = prev_q + 3'd1;
        gray_next = g2b(prev_q) + 3'd1;
        count_dec = g2b(count);
        bin_ok    = (count == bin_next);
        gray_ok   = (count_dec == gray_next);
        mode_ok   = mode_q ? gray_ok : bin_ok;
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        mode_d    = mode_q;
        index_d   = index_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (valid) begin
            prev_d = count;
            case (state_q)
                EMPTY: begin
                    state_d = HUNT;
                    index_d = 3'd0;
                end
                HUNT: begin
                    // Ambiguous steps (000->001, 110->111) cannot identify the mode, so keep hunting.
                    if (bin_ok && !gray_ok) begin
                        state_d = LOCKED;
                        mode_d  = 1'b0;
                        index_d = count;
                    end else if (gray_ok && !bin_ok) begin
                        state_d = LOCKED;
                        mode_d  = 1'b1;
                        index_d = count_dec;
                    end
                end
                LOCKED: begin
                    if (mode_ok) begin
                        index_d = mode_q ? count_dec : count;
                    end else begin
                        state_d = HUNT;
                        index_d = 3'd0;
                        err_d   = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_d = EMPTY;
                    index_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= EMPTY;
            prev_q    <= 3'd0;
            mode_q    <= 1'b0;
            index_q   <= 3'd0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            mode_q    <= mode_d;
            index_q   <= index_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign mode_det  = mode_q;
    assign index     = index_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;

endmodule
